cmd_stream_decoder: RTL

- Clocked successor to the byte-stream command decoder. It sits between the UART/host byte receiver and the PTS code/index registers.
- Parses framed commands from a byte stream with a single-cycle valid strobe. Assembles a multi-byte code for one of N_CH channels, or a one-byte index.
- Commits results atomically with one-cycle ready pulses.
- Adds channel addressing, an inter-byte timeout and error reporting.

---
 rtl/cmd_stream_decoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cmd_stream_decoder.sv
// Framed command decoder: assembles multi-byte channel codes or a one-byte index
// from a strobed byte stream, with inter-byte timeout and error reporting.
module cmd_stream_decoder #(
  parameter int         CODE_BYTES = 4,
  parameter int         N_CH       = 4,
  parameter int         CH_W       = 2,
  parameter int         TIMEOUT    = 1000,
  parameter logic [7:0] OP_CODE    = 8'h01,
  parameter logic [7:0] OP_INDEX   = 8'h02
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [7:0]              imData,
  input  logic                    imData_Valid,
  output logic [8*CODE_BYTES-1:0] oCode,
  output logic [CH_W-1:0]         oCode_Ch,
  output logic                    oCode_Ready,
  output logic [7:0]              oIndex,
  output logic                    oIndex_Ready,
  output logic                    oErr,
  output logic [1:0]              oErr_Code,
  output logic                    oBusy
);
  localparam int CW = 8 * CODE_BYTES;
  localparam int BW = (CODE_BYTES > 1) ? $clog2(CODE_BYTES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] CNT_LAST = BW'(CODE_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CHAN, PAYLOAD, INDEX} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic [CW-1:0]   shadow, shadow_nxt;
  logic [CH_W-1:0] ch, ch_nxt;
  logic            commit_code, commit_index, err;
  logic [1:0]      err_code;
  logic            chan_ok, timeout_hit;

  assign chan_ok     = 32'(imData) < N_CH;
  // Fires on the edge where the idle count would reach TIMEOUT; a byte on that edge wins.
  assign timeout_hit = (TIMEOUT > 0) && (state != IDLE) && !imData_Valid && (tcnt == TO_LAST);
  assign oBusy       = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ch_nxt       = ch;
    shadow_nxt   = shadow;
    commit_code  = 1'b0;
    commit_index = 1'b0;
    err          = 1'b0;
    err_code     = 2'd0;
    if (imData_Valid || state == IDLE) tcnt_nxt = '0;
    else if (tcnt != TO_MAX)           tcnt_nxt = tcnt + 1'b1;
    else                               tcnt_nxt = tcnt;

    if (imData_Valid) begin
      unique case (state)
        IDLE: begin
          if (imData == OP_CODE)       state_nxt = CHAN;
          else if (imData == OP_INDEX) state_nxt = INDEX;
          else begin
            err      = 1'b1;
            err_code = 2'd1;
          end
        end
        CHAN: begin
          if (chan_ok) begin
            state_nxt = PAYLOAD;
            ch_nxt    = imData[CH_W-1:0];
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            err       = 1'b1;
            err_code  = 2'd2;
          end
        end
        PAYLOAD: begin
          for (int k = 0; k < CODE_BYTES; k++)
            if (cnt == BW'(k)) shadow_nxt[8*k +: 8] = imData;
          if (cnt == CNT_LAST) begin
            commit_code = 1'b1;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        INDEX: begin
          commit_index = 1'b1;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = IDLE;
      tcnt_nxt  = '0;
      err       = 1'b1;
      err_code  = 2'd3;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= IDLE;
      cnt    <= '0;
      tcnt   <= '0;
      ch     <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tcnt   <= tcnt_nxt;
      ch     <= ch_nxt;
      shadow <= shadow_nxt;
    end
  end

  // Registered commit: data and its pulse appear together one cycle after the final byte.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oCode        <= '0;
      oCode_Ch     <= '0;
      oCode_Ready  <= 1'b0;
      oIndex       <= '0;
      oIndex_Ready <= 1'b0;
      oErr         <= 1'b0;
      oErr_Code    <= 2'd0;
    end else begin
      oCode_Ready  <= commit_code;
      oIndex_Ready <= commit_index;
      oErr         <= err;
      if (commit_code) begin
        oCode    <= shadow_nxt;
        oCode_Ch <= ch;
      end
      if (commit_index) oIndex <= imData;
      if (err) oErr_Code <= err_code;
    end
  end
endmodule
